// File: rtl/hazard_sequencer_if.sv
// Hazard control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface hazard_sequencer_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_write_reg;
  logic       ex_is_mul;
  logic       branch_taken;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_bubble;
  logic       exmem_bubble;
  logic       busy;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_mem_read, ex_write_reg, ex_is_mul, branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_write,
    input  idex_bubble, exmem_bubble, busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_mem_read, ex_write_reg, ex_is_mul, branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_write,
    output idex_bubble, exmem_bubble, busy
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, multi-cycle
// mul hold in EX, and wrong-path flush after a taken branch.
module hazard_sequencer #(
  parameter int MUL_LAT      = 3,
  parameter int BR_FLUSH_CYC = 1
) (
  input logic            clk,
  input logic            rst,
  hazard_sequencer_if.slave bus
);
  localparam int MAX_LAT     = (MUL_LAT > BR_FLUSH_CYC) ? MUL_LAT : BR_FLUSH_CYC;
  localparam int CW          = $clog2(MAX_LAT) + 1;
  localparam int MUL_INIT_I  = (MUL_LAT > 2) ? (MUL_LAT - 3) : 0;
  localparam int BR_INIT_I   = (BR_FLUSH_CYC > 1) ? (BR_FLUSH_CYC - 2) : 0;
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_INIT_I);
  localparam logic [CW-1:0] BR_INIT  = CW'(BR_INIT_I);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit MUL_STALLS  = (MUL_LAT > 1);
  localparam bit MUL_LONG    = (MUL_LAT > 2);
  localparam bit BR_MULTI    = (BR_FLUSH_CYC > 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    MUL_LAST = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          hazard;

  assign hazard = bus.ex_mem_read && (bus.ex_write_reg != 5'd0) &&
                  ((bus.id_uses_rs && (bus.id_rs == bus.ex_write_reg)) ||
                   (bus.id_uses_rt && (bus.id_rt == bus.ex_write_reg)));

  // State and down-counter; cnt counts remaining extra cycles in MUL_WAIT / FLUSH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        RUN: begin
          if (bus.branch_taken) begin
            if (BR_MULTI) begin
              state_r <= FLUSH;
              cnt_r   <= BR_INIT;
            end else begin
              state_r <= RUN;
            end
          end else if (bus.ex_is_mul && MUL_STALLS) begin
            if (MUL_LONG) begin
              state_r <= MUL_WAIT;
              cnt_r   <= MUL_INIT;
            end else begin
              state_r <= MUL_LAST;
            end
          end else begin
            state_r <= RUN;
          end
        end
        MUL_WAIT: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= MUL_LAST;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        MUL_LAST: state_r <= RUN;
        FLUSH: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= RUN;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= RUN;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Mealy control outputs; everything is forced low while reset is held.
  always_comb begin
    bus.pc_write     = 1'b1;
    bus.ifid_write   = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.idex_write   = 1'b1;
    bus.idex_bubble  = 1'b0;
    bus.exmem_bubble = 1'b0;
    bus.busy         = 1'b0;
    if (rst) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      bus.idex_write = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (bus.branch_taken) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
          end else if (bus.ex_is_mul && MUL_STALLS) begin
            bus.pc_write     = 1'b0;
            bus.ifid_write   = 1'b0;
            bus.idex_write   = 1'b0;
            bus.exmem_bubble = 1'b1;
          end else if (hazard) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_bubble = 1'b1;
          end else begin
            bus.busy = 1'b0;
          end
        end
        MUL_WAIT: begin
          bus.pc_write     = 1'b0;
          bus.ifid_write   = 1'b0;
          bus.idex_write   = 1'b0;
          bus.exmem_bubble = 1'b1;
          bus.busy         = 1'b1;
        end
        MUL_LAST: begin
          // The mul is leaving EX, so only a load-use hazard can still stall.
          bus.busy = 1'b1;
          if (hazard) begin
            bus.pc_write    = 1'b0;
            bus.ifid_write  = 1'b0;
            bus.idex_bubble = 1'b1;
          end else begin
            bus.pc_write = 1'b1;
          end
        end
        FLUSH: begin
          bus.ifid_flush  = 1'b1;
          bus.idex_bubble = 1'b1;
          bus.busy        = 1'b1;
        end
        default: begin
          bus.busy = 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomised self-checking bench: two sequencers with different latencies
// compared against a cycles-remaining reference model.
module tb_hazard_sequencer;
  localparam int MLAT_A = 3;
  localparam int BR_A   = 2;
  localparam int MLAT_B = 2;
  localparam int BR_B   = 1;

  localparam logic [6:0] O_DEF   = 7'b1101000;
  localparam logic [6:0] O_FLUSH = 7'b1111100;
  localparam logic [6:0] O_STALL = 7'b0000010;
  localparam logic [6:0] O_HAZ   = 7'b0001100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] r_rs = 5'd0, r_rt = 5'd0, r_wr = 5'd0;
  logic r_urs = 1'b0, r_urt = 1'b0, r_mr = 1'b0, r_mul = 1'b0, r_br = 1'b0;

  hazard_sequencer_if bus_a ();
  hazard_sequencer_if bus_b ();

  hazard_sequencer #(.MUL_LAT(MLAT_A), .BR_FLUSH_CYC(BR_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  hazard_sequencer #(.MUL_LAT(MLAT_B), .BR_FLUSH_CYC(BR_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  assign bus_a.id_rs = r_rs;        assign bus_b.id_rs = r_rs;
  assign bus_a.id_rt = r_rt;        assign bus_b.id_rt = r_rt;
  assign bus_a.id_uses_rs = r_urs;  assign bus_b.id_uses_rs = r_urs;
  assign bus_a.id_uses_rt = r_urt;  assign bus_b.id_uses_rt = r_urt;
  assign bus_a.ex_mem_read = r_mr;  assign bus_b.ex_mem_read = r_mr;
  assign bus_a.ex_write_reg = r_wr; assign bus_b.ex_write_reg = r_wr;
  assign bus_a.ex_is_mul = r_mul;   assign bus_b.ex_is_mul = r_mul;
  assign bus_a.branch_taken = r_br; assign bus_b.branch_taken = r_br;

  logic [6:0] got [2];
  always_comb begin
    got[0] = {bus_a.pc_write, bus_a.ifid_write, bus_a.ifid_flush, bus_a.idex_write,
              bus_a.idex_bubble, bus_a.exmem_bubble, bus_a.busy};
    got[1] = {bus_b.pc_write, bus_b.ifid_write, bus_b.ifid_flush, bus_b.idex_write,
              bus_b.idex_bubble, bus_b.exmem_bubble, bus_b.busy};
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: remaining stall / flush cycles and a pending "mul leaving" cycle.
  int mlat [2] = '{MLAT_A, MLAT_B};
  int brc  [2] = '{BR_A, BR_B};
  int stall_left [2] = '{0, 0};
  int flush_left [2] = '{0, 0};
  bit in_last [2] = '{1'b0, 1'b0};

  function automatic bit model_h();
    return r_mr && (r_wr != 5'd0) &&
           ((r_urs && (r_rs == r_wr)) || (r_urt && (r_rt == r_wr)));
  endfunction

  function automatic logic [6:0] model_out(int k);
    if (rst) return 7'b0000000;
    if (flush_left[k] > 0) return O_FLUSH | 7'b0000001;
    if (stall_left[k] > 0) return O_STALL | 7'b0000001;
    if (in_last[k]) return (model_h() ? O_HAZ : O_DEF) | 7'b0000001;
    if (r_br) return O_FLUSH;
    if (r_mul && mlat[k] > 1) return O_STALL;
    if (model_h()) return O_HAZ;
    return O_DEF;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      stall_left[k] = 0;
      flush_left[k] = 0;
      in_last[k] = 1'b0;
    end
  endtask

  task automatic model_step(int k);
    if (rst) begin
      stall_left[k] = 0; flush_left[k] = 0; in_last[k] = 1'b0;
    end else if (flush_left[k] > 0) begin
      flush_left[k]--;
    end else if (stall_left[k] > 0) begin
      stall_left[k]--;
      if (stall_left[k] == 0) in_last[k] = 1'b1;
    end else if (in_last[k]) begin
      in_last[k] = 1'b0;
    end else if (r_br) begin
      flush_left[k] = brc[k] - 1;
    end else if (r_mul && mlat[k] > 1) begin
      stall_left[k] = mlat[k] - 2;
      if (mlat[k] == 2) in_last[k] = 1'b1;
    end
  endtask

  task automatic set_rst(logic v);
    rst = v;
    if (v) model_clear();
  endtask

  task automatic set_in(logic mr, logic [4:0] wr, logic [4:0] rs, logic urs,
                        logic [4:0] rt, logic urt, logic mul, logic br);
    r_mr = mr; r_wr = wr; r_rs = rs; r_urs = urs;
    r_rt = rt; r_urt = urt; r_mul = mul; r_br = br;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step(0);
    model_step(1);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_rst(1'b1);
    set_in(1'b1, 5'd8, 5'd8, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (got[k] !== 7'b0000000) begin
        bad++;
        $display("FAIL reset_hold dut%0d got=%b exp=%b", k, got[k], 7'b0000000);
      end
    end
    advance();
    set_rst(1'b0);
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (got[k] !== O_DEF) begin
        bad++;
        $display("FAIL reset_release dut%0d got=%b exp=%b", k, got[k], O_DEF);
      end
    end
    advance();
  endtask

  task automatic test_load_use();
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: set_in(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        1: set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        2: set_in(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        3: set_in(1'b1, 5'd8, 5'd8, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        4: set_in(1'b1, 5'd9, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        5: set_in(1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        6: set_in(1'b1, 5'd31, 5'd31, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        default: set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      endcase
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== model_out(k)) begin
          bad++;
          $display("FAIL load_use s%0d dut%0d got=%b exp=%b", s, k, got[k], model_out(k));
        end
      end
      advance();
    end
  endtask

  task automatic test_mul();
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int s = 0; s < 7; s++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== model_out(k)) begin
          bad++;
          $display("FAIL mul_hold c%0d dut%0d got=%b exp=%b", s, k, got[k], model_out(k));
        end
      end
      advance();
    end
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) advance();
  endtask

  task automatic test_branch();
    for (int s = 0; s < 5; s++) begin
      if (s == 0) set_in(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
      else set_in(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== model_out(k)) begin
          bad++;
          $display("FAIL branch c%0d dut%0d got=%b exp=%b", s, k, got[k], model_out(k));
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 12; s++) begin
      set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, (s % 3 == 0 || s % 3 == 2) ? 1'b1 : 1'b0, 1'b0);
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== model_out(k)) begin
          bad++;
          $display("FAIL b2b c%0d dut%0d got=%b exp=%b", s, k, got[k], model_out(k));
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    advance();
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    set_rst(1'b1);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (got[k] !== 7'b0000000) begin
        bad++;
        $display("FAIL reset_mid dut%0d got=%b exp=%b", k, got[k], 7'b0000000);
      end
    end
    #1;
    set_rst(1'b0);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (got[k] !== O_DEF) begin
        bad++;
        $display("FAIL reset_mid_release dut%0d got=%b exp=%b", k, got[k], O_DEF);
      end
    end
    advance();
  endtask

  task automatic test_random();
    for (int s = 0; s < 600; s++) begin
      set_rst(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
      set_in(($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom),
             ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (got[k] !== model_out(k)) begin
          bad++;
          $display("FAIL random c%0d dut%0d got=%b exp=%b", cyc, k, got[k], model_out(k));
        end
      end
      advance();
    end
    set_rst(1'b0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_use();
    test_mul();
    test_branch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
